alu_control_seq: RTL and testbench
==================================

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

Interface
REQ-001 Parameter OPW, default 3, ALUop width.
REQ-002 Parameter FUNCW, default 3, R-type function field width.
REQ-003 Parameter CTRLW, default 3, ALU control code width.
REQ-004 Parameter SHW, default 4, shift-amount width; the maximum shift is 2^SHW-1 steps.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  ALUop/Func/shamt present this cycle.
REQ-008 in_ready  output  1  the block accepts the op this cycle.
REQ-009 ALUop  input  OPW  main-control ALU operation class.
REQ-010 Func  input  FUNCW  R-type function field.
REQ-011 shamt  input  SHW  shift amount for variable shifts.
REQ-012 stall  input  1  the downstream ALU cannot take a new control word; all outputs and state hold.
REQ-013 ctrl  output  CTRLW  registered ALU control code.
REQ-014 ctrl_valid  output  1  ctrl is meaningful this cycle.
REQ-015 ctrl_last  output  1  final control word of the current op.
REQ-016 zero_shift  output  1  the current word is a shift with shamt=0, and the ALU passes the operand through.
REQ-017 illegal  output  1  the current op had an undefined ALUop; ctrl is forced to ADD.
REQ-018 busy  output  1  a multi-step shift sequence is in progress.

Function
REQ-019 Control codes: AND=000, OR=001, ADD=010, XOR=011, SLL1=100, SRL1=101, SUB=110, SLT=111.
REQ-020 ALUop decode (non-R): 000->ADD, 001->SUB, 010->AND, 011->OR, 100->SLT, 101->XOR, 110->ADD with illegal=1; 111 selects R-type.
REQ-021 R-type Func decode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLLV, 111 SRLV.
REQ-022 Acceptance occurs when in_valid=1 and in_ready=1.
REQ-023 Latency: an accepted op's first control word appears with ctrl_valid=1 in the next cycle.
REQ-024 Single-step ops produce one word with ctrl_last=1.
REQ-025 SLLV/SRLV with shamt=N>0 produce N consecutive words of SLL1/SRL1; ctrl_last=1 only on the Nth word.
REQ-026 During SLLV/SRLV, busy=1 while more than one word remains.
REQ-027 SLLV/SRLV with shamt=0 produce one word with the shift code, zero_shift=1 and ctrl_last=1.
REQ-028 FSM states are IDLE, ISSUE and SHIFT.
REQ-029 IDLE->ISSUE on acceptance of a single-step op, or a shift op with shamt≤1.
REQ-030 IDLE->SHIFT on acceptance of a shift op with shamt≥2.
REQ-031 ISSUE->ISSUE/SHIFT on back-to-back acceptance; otherwise ISSUE->IDLE.
REQ-032 In SHIFT a down-counter (SHW bits) loads shamt-1 at acceptance and decrements each non-stalled cycle; SHIFT exits when the word with counter=0 is issued.
REQ-033 in_ready = !stall && !(state==SHIFT && counter>0), which allows back-to-back issue with no bubble after ctrl_last.
REQ-034 With stall=1: ctrl, ctrl_valid, ctrl_last, zero_shift, illegal, counter and state all hold; no acceptance occurs.
REQ-035 ctrl_valid drops to 0 in the cycle after a ctrl_last word when nothing was accepted.
REQ-036 The counter never wraps; shamt=2^SHW-1 yields exactly 2^SHW-1 words.

Reset
REQ-037 Reset asserted at any time (including mid-SHIFT) forces state=IDLE, counter=0, and ctrl=000, ctrl_valid=0, ctrl_last=0, zero_shift=0, illegal=0, busy=0, asynchronously.
REQ-038 in_ready follows REQ-033 during and after reset; no op is accepted while reset=1.

Structure
REQ-039 Package alu_ctrl_pkg holds the control-code constants, the ALUop and Func encodings, and the FSM state enumeration.
REQ-040 Combinational decoding lives in sub-module alu_ctrl_decode (ALUop, Func -> code, is_shift, illegal); alu_control_seq holds the FSM, counter and output registers.

Verification
REQ-041 ALUop=111, Func=000, accepted -> next cycle ctrl=010, ctrl_valid=1, ctrl_last=1.
REQ-042 ALUop=111, Func=110, shamt=3 -> three words ctrl=100 with ctrl_last only on the 3rd; in_ready=0 for the first two words; busy=1 for the first two words.
REQ-043 ALUop=111, Func=111, shamt=0 -> one word ctrl=101, zero_shift=1, ctrl_last=1.
REQ-044 ALUop=110 -> ctrl=010, illegal=1; then ALUop=001 back-to-back -> ctrl=110, illegal=0 with no bubble.
REQ-045 SRLV with shamt=5, stall=1 for 2 cycles on the 2nd word -> the 2nd word is held 3 cycles, the total is still 5 words, and the counter is frozen during the stall.
REQ-046 reset pulsed during the 3rd word of SLLV with shamt=15 -> all outputs clear immediately; after release, an ALUop=000 op issues ctrl=010 normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: control codes, ALUop and
// R-type function values, and the FSM state type.
package alu_ctrl_pkg;

  localparam logic [2:0] CTRL_AND  = 3'b000;
  localparam logic [2:0] CTRL_OR   = 3'b001;
  localparam logic [2:0] CTRL_ADD  = 3'b010;
  localparam logic [2:0] CTRL_XOR  = 3'b011;
  localparam logic [2:0] CTRL_SLL1 = 3'b100;
  localparam logic [2:0] CTRL_SRL1 = 3'b101;
  localparam logic [2:0] CTRL_SUB  = 3'b110;
  localparam logic [2:0] CTRL_SLT  = 3'b111;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_AND   = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;
  localparam logic [2:0] ALUOP_XOR   = 3'b101;
  localparam logic [2:0] ALUOP_ILL   = 3'b110;
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_SUB  = 3'b001;
  localparam logic [2:0] FN_AND  = 3'b010;
  localparam logic [2:0] FN_OR   = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_SLT  = 3'b101;
  localparam logic [2:0] FN_SLLV = 3'b110;
  localparam logic [2:0] FN_SRLV = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    SHIFT = 2'b10
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational ALUop/Func decode into a control code plus the
// variable-shift and undefined-ALUop flags.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int FUNCW = 3,
  parameter int CTRLW = 3
) (
  input  logic [OPW-1:0]   ALUop,
  input  logic [FUNCW-1:0] Func,
  output logic [CTRLW-1:0] code,
  output logic             is_shift,
  output logic             illegal
);

  logic [2:0] c;

  always_comb begin
    c        = CTRL_ADD;
    is_shift = 1'b0;
    illegal  = 1'b0;
    case (ALUop)
      ALUOP_ADD: c = CTRL_ADD;
      ALUOP_SUB: c = CTRL_SUB;
      ALUOP_AND: c = CTRL_AND;
      ALUOP_OR:  c = CTRL_OR;
      ALUOP_SLT: c = CTRL_SLT;
      ALUOP_XOR: c = CTRL_XOR;
      ALUOP_ILL: illegal = 1'b1;
      ALUOP_RTYPE: begin
        case (Func)
          FN_ADD:  c = CTRL_ADD;
          FN_SUB:  c = CTRL_SUB;
          FN_AND:  c = CTRL_AND;
          FN_OR:   c = CTRL_OR;
          FN_XOR:  c = CTRL_XOR;
          FN_SLT:  c = CTRL_SLT;
          FN_SLLV: begin c = CTRL_SLL1; is_shift = 1'b1; end
          FN_SRLV: begin c = CTRL_SRL1; is_shift = 1'b1; end
          default: c = CTRL_ADD;
        endcase
      end
      default: c = CTRL_ADD;
    endcase
  end

  assign code = CTRLW'(c);

endmodule

// File: rtl/alu_control_seq.sv
// ALU control sequencer: accepts one op at a time and emits registered control
// words, expanding variable shifts into shamt single-bit steps.
// Handshake: an op is taken on a rising edge where in_valid && in_ready; the
// op inputs must stay stable while in_valid=1 and in_ready=0.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int OPW   = 3,
  parameter int FUNCW = 3,
  parameter int CTRLW = 3,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   ALUop,
  input  logic [FUNCW-1:0] Func,
  input  logic [SHW-1:0]   shamt,
  input  logic             stall,
  output logic [CTRLW-1:0] ctrl,
  output logic             ctrl_valid,
  output logic             ctrl_last,
  output logic             zero_shift,
  output logic             illegal,
  output logic             busy,
  output logic [1:0]       dbg_state,
  output logic [SHW-1:0]   dbg_count
);

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [CTRLW-1:0] ctrl_q, ctrl_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             zs_q, zs_d, ill_q, ill_d;

  logic [CTRLW-1:0] dec_code;
  logic             dec_is_shift, dec_illegal;
  logic             accept, stepping;

  alu_ctrl_decode #(.OPW(OPW), .FUNCW(FUNCW), .CTRLW(CTRLW)) u_decode (
    .ALUop    (ALUop),
    .Func     (Func),
    .code     (dec_code),
    .is_shift (dec_is_shift),
    .illegal  (dec_illegal)
  );

  // SHIFT always holds a nonzero count; the last word is shown from ISSUE.
  assign stepping = (state_q == SHIFT) && (cnt_q != '0);
  assign in_ready = !stall && !stepping;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      zs_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      zs_q    <= zs_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    last_d  = last_q;
    zs_d    = zs_q;
    ill_d   = ill_q;
    if (!stall) begin
      if (stepping) begin
        cnt_d   = cnt_q - SHW'(1);
        valid_d = 1'b1;
        last_d  = (cnt_q == SHW'(1));
        zs_d    = 1'b0;
        ill_d   = 1'b0;
        if (cnt_q == SHW'(1)) state_d = ISSUE;
      end else if (accept) begin
        ctrl_d  = dec_code;
        valid_d = 1'b1;
        ill_d   = dec_illegal;
        zs_d    = dec_is_shift && (shamt == '0);
        if (dec_is_shift && (shamt > SHW'(1))) begin
          state_d = SHIFT;
          cnt_d   = shamt - SHW'(1);
          last_d  = 1'b0;
        end else begin
          state_d = ISSUE;
          cnt_d   = '0;
          last_d  = 1'b1;
        end
      end else begin
        // ctrl keeps its last code; only the qualifiers drop.
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        zs_d    = 1'b0;
        ill_d   = 1'b0;
      end
    end
  end

  assign ctrl       = ctrl_q;
  assign ctrl_valid = valid_q;
  assign ctrl_last  = last_q;
  assign zero_shift = zs_q;
  assign illegal    = ill_q;
  assign busy       = stepping;
  assign dbg_state  = state_q;
  assign dbg_count  = cnt_q;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, shift expansion, stall
// hold, back-to-back issue and asynchronous reset.
module tb_alu_control_seq;

  logic       clk = 1'b0;
  logic       reset, in_valid, stall;
  logic [2:0] ALUop, Func;
  logic [3:0] shamt;
  logic       in_ready, ctrl_valid, ctrl_last, zero_shift, illegal, busy;
  logic [2:0] ctrl;
  logic [1:0] dbg_state;
  logic [3:0] dbg_count;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // {ctrl[2:0], valid, last, zero_shift, illegal, busy, in_ready}
  wire [8:0] obs = {ctrl, ctrl_valid, ctrl_last, zero_shift, illegal, busy, in_ready};

  alu_control_seq dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUop      (ALUop),
    .Func       (Func),
    .shamt      (shamt),
    .stall      (stall),
    .ctrl       (ctrl),
    .ctrl_valid (ctrl_valid),
    .ctrl_last  (ctrl_last),
    .zero_shift (zero_shift),
    .illegal    (illegal),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [2:0] fn, input logic [3:0] sh);
    in_valid = 1'b1;
    ALUop    = op;
    Func     = fn;
    shamt    = sh;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0;
    drive_op(3'b001, 3'b000, 4'd0);
    step(); step();
    total_cnt++;
    if (obs !== 9'b000_000001) $display("FAIL reset_outputs obs=%b exp=%b", obs, 9'b000_000001);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 2'b00 || dbg_count !== 4'd0)
      $display("FAIL reset_state state=%0d cnt=%0d exp=0/0", dbg_state, dbg_count);
    else pass_cnt++;
    in_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_rtype_add();
    drive_op(3'b111, 3'b000, 4'd0);
    step(); in_valid = 1'b0;
    total_cnt++;
    if (obs !== 9'b010_110001) $display("FAIL rtype_add obs=%b exp=%b", obs, 9'b010_110001);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== 9'b010_000001) $display("FAIL add_valid_drop obs=%b exp=%b", obs, 9'b010_000001);
    else pass_cnt++;
  endtask

  task automatic test_sllv3();
    logic [8:0] exp_obs [4];
    logic [3:0] exp_cnt [4];
    exp_obs = '{9'b100_100010, 9'b100_100010, 9'b100_110001, 9'b100_000001};
    exp_cnt = '{4'd2, 4'd1, 4'd0, 4'd0};
    drive_op(3'b111, 3'b110, 4'd3);
    step(); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if (obs !== exp_obs[k] || dbg_count !== exp_cnt[k])
        $display("FAIL sllv3_word%0d obs=%b cnt=%0d exp=%b cnt=%0d", k + 1, obs, dbg_count, exp_obs[k], exp_cnt[k]);
      else pass_cnt++;
      if (k < 3) step();
    end
  endtask

  task automatic test_short_shifts();
    drive_op(3'b111, 3'b111, 4'd0);
    step(); in_valid = 1'b0;
    total_cnt++;
    if (obs !== 9'b101_111001) $display("FAIL srlv0 obs=%b exp=%b", obs, 9'b101_111001);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== 9'b101_000001) $display("FAIL srlv0_drop obs=%b exp=%b", obs, 9'b101_000001);
    else pass_cnt++;
    drive_op(3'b111, 3'b110, 4'd1);
    step(); in_valid = 1'b0;
    total_cnt++;
    if (obs !== 9'b100_110001) $display("FAIL sllv1 obs=%b exp=%b", obs, 9'b100_110001);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    drive_op(3'b110, 3'b000, 4'd0);
    step();
    total_cnt++;
    if (obs !== 9'b010_110101) $display("FAIL illegal_op obs=%b exp=%b", obs, 9'b010_110101);
    else pass_cnt++;
    drive_op(3'b001, 3'b000, 4'd0);
    step();
    total_cnt++;
    if (obs !== 9'b110_110001) $display("FAIL b2b_sub obs=%b exp=%b", obs, 9'b110_110001);
    else pass_cnt++;
    // ADD waits behind a two-step shift and issues right after its last word.
    drive_op(3'b111, 3'b110, 4'd2);
    step();
    drive_op(3'b000, 3'b000, 4'd0);
    total_cnt++;
    if (obs !== 9'b100_100010) $display("FAIL b2b_shift_w1 obs=%b exp=%b", obs, 9'b100_100010);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== 9'b100_110001) $display("FAIL b2b_shift_w2 obs=%b exp=%b", obs, 9'b100_110001);
    else pass_cnt++;
    step(); in_valid = 1'b0;
    total_cnt++;
    if (obs !== 9'b010_110001) $display("FAIL b2b_after_shift obs=%b exp=%b", obs, 9'b010_110001);
    else pass_cnt++;
    step();
    total_cnt++;
    if (obs !== 9'b010_000001) $display("FAIL b2b_drop obs=%b exp=%b", obs, 9'b010_000001);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    logic [2:0] t_op   [13];
    logic [2:0] t_fn   [13];
    logic [2:0] t_code [13];
    logic       t_ill  [13];
    t_op   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd6};
    t_fn   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    t_code = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011,
               3'b010, 3'b110, 3'b000, 3'b001, 3'b011, 3'b111, 3'b010};
    t_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 13; i++) begin
      drive_op(t_op[i], t_fn[i], 4'd0);
      step();
      total_cnt++;
      if (ctrl !== t_code[i] || illegal !== t_ill[i] || ctrl_valid !== 1'b1 || ctrl_last !== 1'b1)
        $display("FAIL decode_%0d op=%b fn=%b ctrl=%b ill=%b v=%b l=%b exp ctrl=%b ill=%b v=1 l=1",
                 i, t_op[i], t_fn[i], ctrl, illegal, ctrl_valid, ctrl_last, t_code[i], t_ill[i]);
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_stall();
    logic       s_pat [7];
    logic [3:0] e_cnt [7];
    logic       e_val [7];
    logic       e_last[7];
    int words, held;
    s_pat  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_cnt  = '{4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
    e_val  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    e_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    drive_op(3'b111, 3'b111, 4'd5);
    step(); in_valid = 1'b0;
    words = ctrl_valid ? 1 : 0;
    held  = 0;
    total_cnt++;
    if (obs !== 9'b101_100010 || dbg_count !== 4'd4)
      $display("FAIL stall_w1 obs=%b cnt=%0d exp=%b cnt=4", obs, dbg_count, 9'b101_100010);
    else pass_cnt++;
    for (int i = 0; i < 7; i++) begin
      stall = s_pat[i];
      step();
      if (ctrl_valid && !s_pat[i]) words++;
      if (ctrl_valid && dbg_count == 4'd3) held++;
      total_cnt++;
      if (dbg_count !== e_cnt[i] || ctrl_valid !== e_val[i] || ctrl_last !== e_last[i] || ctrl !== 3'b101)
        $display("FAIL stall_cyc%0d ctrl=%b v=%b l=%b cnt=%0d exp ctrl=101 v=%b l=%b cnt=%0d",
                 i, ctrl, ctrl_valid, ctrl_last, dbg_count, e_val[i], e_last[i], e_cnt[i]);
      else pass_cnt++;
      if (s_pat[i]) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stall_ready cyc%0d in_ready=%b exp=0", i, in_ready);
        else pass_cnt++;
      end
    end
    stall = 1'b0;
    total_cnt++;
    if (words !== 5 || held !== 3)
      $display("FAIL stall_counts words=%0d held=%0d exp words=5 held=3", words, held);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    drive_op(3'b111, 3'b110, 4'd15);
    step(); in_valid = 1'b0;
    step(); step();
    total_cnt++;
    if (dbg_count !== 4'd12 || ctrl !== 3'b100 || busy !== 1'b1)
      $display("FAIL pre_reset_w3 cnt=%0d ctrl=%b busy=%b exp cnt=12 ctrl=100 busy=1", dbg_count, ctrl, busy);
    else pass_cnt++;
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (obs !== 9'b000_000001 || dbg_state !== 2'b00 || dbg_count !== 4'd0)
      $display("FAIL async_reset obs=%b st=%0d cnt=%0d exp=%b st=0 cnt=0", obs, dbg_state, dbg_count, 9'b000_000001);
    else pass_cnt++;
    drive_op(3'b001, 3'b000, 4'd0);
    step();
    total_cnt++;
    if (ctrl_valid !== 1'b0 || ctrl !== 3'b000)
      $display("FAIL no_accept_in_reset v=%b ctrl=%b exp v=0 ctrl=000", ctrl_valid, ctrl);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    drive_op(3'b000, 3'b000, 4'd0);
    step(); in_valid = 1'b0;
    total_cnt++;
    if (obs !== 9'b010_110001) $display("FAIL post_reset_add obs=%b exp=%b", obs, 9'b010_110001);
    else pass_cnt++;
    step();
  endtask

  task automatic test_max_shift();
    int  words;
    bit  done;
    drive_op(3'b111, 3'b110, 4'd15);
    step(); in_valid = 1'b0;
    total_cnt++;
    if (dbg_count !== 4'd14 || busy !== 1'b1)
      $display("FAIL max_shift_load cnt=%0d busy=%b exp cnt=14 busy=1", dbg_count, busy);
    else pass_cnt++;
    words = 0;
    done  = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (ctrl_valid) words++;
      if (ctrl_last) done = 1'b1;
      else step();
    end
    total_cnt++;
    if (!done || words !== 15)
      $display("FAIL max_shift_words words=%0d last_seen=%0d exp words=15 last_seen=1", words, done);
    else pass_cnt++;
    step();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0;
    ALUop = '0; Func = '0; shamt = '0;
    test_reset();
    test_rtype_add();
    test_sllv3();
    test_short_shifts();
    test_back_to_back();
    test_decode();
    test_stall();
    test_reset_mid_shift();
    test_max_shift();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
